fpga_top_mul_pipe_sat: RTL and testbench
========================================

// Module: fpga_top_mul_pipe_sat
// PURPOSE
// Parametrised, pipelined integer multiplier for the fpga_top CNN datapath (MAC/requant stages).
// Generalises the fixed 10s x 10ns -> 16 combinational multiplier:
// - per-operand signedness;
// - configurable pipeline depth;
// - fixed-point right shift;
// - saturate or wrap on narrowing;
// - overflow flag;
// - valid/ready flow control with backpressure.
// PARAMETERS
// A_WIDTH    10  width of operand a (bits)
// B_WIDTH    10  width of operand b (bits)
// OUT_WIDTH  16  width of result p (bits), 1..A_WIDTH+B_WIDTH
// A_SIGNED   1   1: a is two's complement, 0: a is unsigned
// B_SIGNED   0   1: b is two's complement, 0: b is unsigned (zero-extended)
// SHIFT      0   right shift applied to the full product before narrowing, 0..A_WIDTH+B_WIDTH-1
// SAT        1   1: clamp to OUT_WIDTH range, 0: keep low OUT_WIDTH bits (wrap)
// NUM_STAGE  2   pipeline register stages from input to output, >=1
// PORTS
// ap_clk     in   1          clock, all logic on rising edge
// ap_rst_n   in   1          asynchronous active-low reset
// in_valid   in   1          a/b hold a valid operand pair
// in_ready   out  1          block accepts an operand pair this cycle
// a          in   A_WIDTH    operand a
// b          in   B_WIDTH    operand b
// out_valid  out  1          p/ovf hold a valid result
// out_ready  in   1          downstream accepts the result this cycle
// p          out  OUT_WIDTH  narrowed result
// ovf        out  1          result lost information (clamped or wrapped); qualified by out_valid
// BEHAVIOUR
// - Reset (ap_rst_n=0, async assert, sync deassert in the clock domain):
//   all stage valid bits=0, out_valid=0, p=0, ovf=0; in_ready=1 once out of reset.
// - Arithmetic: extend a and b per A_SIGNED/B_SIGNED to A_WIDTH+B_WIDTH+1 signed.
//   Exact product P is kept in that width; no intermediate truncation.
// - Shift: Q = P >>> SHIFT (arithmetic), i.e. truncation toward -infinity.
// - Result signed iff A_SIGNED|B_SIGNED. Range:
//   signed [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; unsigned [0, 2^OUT_WIDTH-1].
// - SAT=1: out-of-range Q clamps to the nearest bound, ovf=1; otherwise p=Q[OUT_WIDTH-1:0], ovf=0.
// - SAT=0: p=Q[OUT_WIDTH-1:0] always; ovf=1 iff Q is out of range.
// - Pipeline: NUM_STAGE register stages, each carrying data plus a valid bit.
//   advance = ~out_valid | out_ready; in_ready = advance (combinational).
//   On advance all stages shift by one; transfer in when in_valid & in_ready.
// - Latency: a pair accepted at cycle t appears with out_valid=1 at t+NUM_STAGE when no stall occurred.
// - Throughput: 1 result/cycle while out_ready=1.
// - Each stall cycle (out_valid & ~out_ready) freezes every stage, p and ovf.
//   in_ready=0 during a stall; a, b and in_valid are ignored.
// - Bubbles (in_valid=0 on advance) propagate as valid=0 stages; no reordering, no drop, no duplication.
// - Simultaneous out_ready & in_valid with a full pipeline: the output retires and the input is accepted in the same cycle.
// - Reset mid-operation discards every in-flight result; no output handshake completes for them.
// - p/ovf are don't-care while out_valid=0, but hold their last value (no X).
// TESTING (defaults unless noted)
// 1. a=100, b=200, out_ready=1 -> after 2 cycles out_valid=1, p=20000, ovf=0.
// 2. a=-512, b=1023 (P=-523776) -> p=-32768 (0x8000), ovf=1.
//    a=511, b=1023 -> p=32767 (0x7FFF), ovf=1.
// 3. SAT=0: a=511, b=1023 (P=0x7FA01) -> p=0xFA01, ovf=1.
//    SHIFT=4: a=-3, b=5 -> p=-1 (0xFFFF), ovf=0.
// 4. Unsigned mode, A_SIGNED=0, OUT_WIDTH=8: a=16, b=16 -> p=255, ovf=1;
//    a=15, b=17 -> p=255, ovf=0.
// 5. Stream 8 pairs back-to-back. Hold out_ready=0 for 3 cycles mid-stream:
//    in_ready=0 and p frozen during the stall; all 8 products emerge in order, none lost or duplicated.
// 6. Assert ap_rst_n=0 for 1 cycle with 2 results in flight -> out_valid=0, p=0, ovf=0 immediately.
//    The next accepted pair yields its correct result after NUM_STAGE cycles.

Source files
------------

// File: rtl/fpga_top_mul_pipe_sat.sv
// Pipelined integer multiplier with optional fixed-point shift and saturating or wrapping
// narrowing, flow-controlled by valid/ready with backpressure.
module fpga_top_mul_pipe_sat #(
   parameter int A_WIDTH   = 10,
   parameter int B_WIDTH   = 10,
   parameter int OUT_WIDTH = 16,
   parameter int A_SIGNED  = 1,
   parameter int B_SIGNED  = 0,
   parameter int SHIFT     = 0,
   parameter int SAT       = 1,
   parameter int NUM_STAGE = 2
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [A_WIDTH-1:0]   a,
   input  logic [B_WIDTH-1:0]   b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] p,
   output logic                 ovf
);

   localparam int PW = A_WIDTH + B_WIDTH + 1;
   localparam bit RES_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);
   localparam logic [PW-1:0] ONE_U = {{(PW-1){1'b0}}, 1'b1};
   // Result bounds held in the full product width so the range test needs no narrowing.
   localparam logic signed [PW-1:0] MAX_S = RES_SIGNED ?
      $signed((ONE_U << (OUT_WIDTH-1)) - ONE_U) : $signed((ONE_U << OUT_WIDTH) - ONE_U);
   localparam logic signed [PW-1:0] MIN_S = RES_SIGNED ?
      $signed(~((ONE_U << (OUT_WIDTH-1)) - ONE_U)) : $signed({PW{1'b0}});

   logic signed [A_WIDTH:0]   a_ext_s;
   logic signed [B_WIDTH:0]   b_ext_s;
   logic signed [PW-1:0]      prod_s;
   logic signed [PW-1:0]      quot_s;
   logic                      over_s;
   logic                      under_s;
   logic [OUT_WIDTH-1:0]      res_s;
   logic                      res_ovf_s;
   logic                      advance_s;

   logic [NUM_STAGE-1:0]      vld_q, vld_d;
   logic [NUM_STAGE-1:0]      ovfs_q, ovfs_d;
   logic [OUT_WIDTH-1:0]      data_q [NUM_STAGE];
   logic [OUT_WIDTH-1:0]      data_d [NUM_STAGE];

   // Exact product, arithmetic shift and narrowing of the incoming operand pair.
   always_comb begin
      a_ext_s   = {((A_SIGNED != 0) ? a[A_WIDTH-1] : 1'b0), a};
      b_ext_s   = {((B_SIGNED != 0) ? b[B_WIDTH-1] : 1'b0), b};
      prod_s    = PW'(a_ext_s) * PW'(b_ext_s);
      quot_s    = prod_s >>> SHIFT;
      over_s    = (quot_s > MAX_S);
      under_s   = (quot_s < MIN_S);
      res_s     = quot_s[OUT_WIDTH-1:0];
      res_ovf_s = over_s | under_s;
      if (SAT != 0) begin
         if (over_s) begin
            res_s = MAX_S[OUT_WIDTH-1:0];
         end else if (under_s) begin
            res_s = MIN_S[OUT_WIDTH-1:0];
         end else begin
            res_s = quot_s[OUT_WIDTH-1:0];
         end
      end else begin
         res_s = quot_s[OUT_WIDTH-1:0];
      end
   end

   // Stage advance: data only moves behind a valid bit so bubbles leave p/ovf untouched.
   always_comb begin
      advance_s = ~vld_q[NUM_STAGE-1] | out_ready;
      vld_d     = vld_q;
      ovfs_d    = ovfs_q;
      data_d    = data_q;
      if (advance_s) begin
         vld_d[0] = in_valid;
         if (in_valid) begin
            data_d[0] = res_s;
            ovfs_d[0] = res_ovf_s;
         end else begin
            data_d[0] = data_q[0];
            ovfs_d[0] = ovfs_q[0];
         end
         for (int k = 1; k < NUM_STAGE; k++) begin
            vld_d[k] = vld_q[k-1];
            if (vld_q[k-1]) begin
               data_d[k] = data_q[k-1];
               ovfs_d[k] = ovfs_q[k-1];
            end else begin
               data_d[k] = data_q[k];
               ovfs_d[k] = ovfs_q[k];
            end
         end
      end else begin
         vld_d = vld_q;
      end
   end

   // Pipeline registers.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         vld_q  <= {NUM_STAGE{1'b0}};
         ovfs_q <= {NUM_STAGE{1'b0}};
         for (int k = 0; k < NUM_STAGE; k++) begin
            data_q[k] <= {OUT_WIDTH{1'b0}};
         end
      end else begin
         vld_q  <= vld_d;
         ovfs_q <= ovfs_d;
         for (int k = 0; k < NUM_STAGE; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   assign in_ready  = advance_s;
   assign out_valid = vld_q[NUM_STAGE-1];
   assign p         = data_q[NUM_STAGE-1];
   assign ovf       = ovfs_q[NUM_STAGE-1];

endmodule

// File: tb/tb_fpga_top_mul_pipe_sat.sv
// Directed bench for fpga_top_mul_pipe_sat: four parameterisations driven in lockstep
// from shared inputs, each checked against hand-computed results.
module tb_fpga_top_mul_pipe_sat;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [9:0]  a, b;

   logic        rdy_d, vld_d, ovf_d;
   logic [15:0] p_d;
   logic        rdy_w, vld_w, ovf_w;
   logic [15:0] p_w;
   logic        rdy_s, vld_s, ovf_s;
   logic [15:0] p_s;
   logic        rdy_u, vld_u, ovf_u;
   logic [7:0]  p_u;

   int checks   = 0;
   int failures = 0;

   logic [9:0]  va [8] = '{10'd1, 10'd3, 10'h3FB, 10'd7, 10'h3F7, 10'd11, 10'd13, 10'h3F1};
   logic [9:0]  vb [8] = '{10'd2, 10'd4, 10'd6, 10'd8, 10'd10, 10'd12, 10'd14, 10'd16};
   logic [15:0] ve [8] = '{16'd2, 16'd12, 16'hFFE2, 16'd56, 16'hFFA6, 16'd132, 16'd182, 16'hFF10};

   always #5 ap_clk = ~ap_clk;

   fpga_top_mul_pipe_sat u_dflt (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy_d),
      .a(a), .b(b), .out_valid(vld_d), .out_ready(out_ready), .p(p_d), .ovf(ovf_d));

   fpga_top_mul_pipe_sat #(.SAT(0)) u_wrap (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy_w),
      .a(a), .b(b), .out_valid(vld_w), .out_ready(out_ready), .p(p_w), .ovf(ovf_w));

   fpga_top_mul_pipe_sat #(.SHIFT(4)) u_shift (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy_s),
      .a(a), .b(b), .out_valid(vld_s), .out_ready(out_ready), .p(p_s), .ovf(ovf_s));

   fpga_top_mul_pipe_sat #(.A_SIGNED(0), .OUT_WIDTH(8)) u_uns (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy_u),
      .a(a), .b(b), .out_valid(vld_u), .out_ready(out_ready), .p(p_u), .ovf(ovf_u));

   task automatic tick;
      @(posedge ap_clk);
      #1;
   endtask

   // One pair accepted, result visible on the outputs when this returns.
   task automatic send(input logic [9:0] av, input logic [9:0] bv);
      a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      ap_rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = 10'd0; b = 10'd0;
      #12;
      checks++; if (vld_d !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", vld_d); end
      checks++; if (p_d !== 16'h0000) begin failures++; $display("FAIL reset_p: got %h expected 0000", p_d); end
      checks++; if (ovf_d !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", ovf_d); end
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      tick();
      checks++; if (rdy_d !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", rdy_d); end
   endtask

   task automatic test_basic;
      a = 10'd100; b = 10'd200; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (vld_d !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b expected 0", vld_d); end
      tick();
      checks++; if (vld_d !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", vld_d); end
      checks++; if (p_d !== 16'd20000) begin failures++; $display("FAIL basic_p: got %0d expected 20000", p_d); end
      checks++; if (ovf_d !== 1'b0) begin failures++; $display("FAIL basic_ovf: got %b expected 0", ovf_d); end
      checks++; if (p_s !== 16'd1250) begin failures++; $display("FAIL basic_shift_p: got %0d expected 1250", p_s); end
      checks++; if (p_u !== 8'd255 || ovf_u !== 1'b1) begin failures++; $display("FAIL basic_uns_sat: got %0d/%b expected 255/1", p_u, ovf_u); end
   endtask

   task automatic test_saturate;
      send(10'h200, 10'd1023);
      checks++; if (p_d !== 16'h8000 || ovf_d !== 1'b1) begin failures++; $display("FAIL sat_neg: got %h/%b expected 8000/1", p_d, ovf_d); end
      send(10'd511, 10'd1023);
      checks++; if (p_d !== 16'h7FFF || ovf_d !== 1'b1) begin failures++; $display("FAIL sat_pos: got %h/%b expected 7fff/1", p_d, ovf_d); end
   endtask

   task automatic test_wrap_shift;
      send(10'd511, 10'd1023);
      checks++; if (p_w !== 16'hFA01 || ovf_w !== 1'b1) begin failures++; $display("FAIL wrap_pos: got %h/%b expected fa01/1", p_w, ovf_w); end
      send(10'h3FD, 10'd5);
      checks++; if (p_s !== 16'hFFFF || ovf_s !== 1'b0) begin failures++; $display("FAIL shift_neg: got %h/%b expected ffff/0", p_s, ovf_s); end
      checks++; if (p_d !== 16'hFFF1 || ovf_d !== 1'b0) begin failures++; $display("FAIL small_neg: got %h/%b expected fff1/0", p_d, ovf_d); end
      checks++; if (p_w !== 16'hFFF1 || ovf_w !== 1'b0) begin failures++; $display("FAIL wrap_in_range: got %h/%b expected fff1/0", p_w, ovf_w); end
   endtask

   task automatic test_unsigned;
      send(10'd16, 10'd16);
      checks++; if (p_u !== 8'd255 || ovf_u !== 1'b1) begin failures++; $display("FAIL uns_256: got %0d/%b expected 255/1", p_u, ovf_u); end
      send(10'd15, 10'd17);
      checks++; if (p_u !== 8'd255 || ovf_u !== 1'b0) begin failures++; $display("FAIL uns_255: got %0d/%b expected 255/0", p_u, ovf_u); end
      send(10'd0, 10'd1023);
      checks++; if (p_u !== 8'd0 || ovf_u !== 1'b0) begin failures++; $display("FAIL uns_zero: got %0d/%b expected 0/0", p_u, ovf_u); end
   endtask

   task automatic test_back_to_back;
      int sent = 0;
      int recv = 0;
      int stalls = 0;
      logic prev_stall = 1'b0;
      logic [15:0] p_prev = 16'h0000;
      in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick();
      for (int cyc = 0; cyc < 30; cyc++) begin
         in_valid = (sent < 8);
         if (sent < 8) begin a = va[sent]; b = vb[sent]; end
         out_ready = !(cyc >= 4 && cyc <= 6);
         #1;
         if (vld_d && !out_ready) begin
            stalls++;
            checks++; if (rdy_d !== 1'b0) begin failures++; $display("FAIL stall_ready: got %b expected 0", rdy_d); end
            if (prev_stall) begin
               checks++; if (p_d !== p_prev) begin failures++; $display("FAIL stall_freeze: got %h expected %h", p_d, p_prev); end
            end
            prev_stall = 1'b1;
            p_prev = p_d;
         end else begin
            prev_stall = 1'b0;
         end
         if (vld_d && out_ready) begin
            checks++;
            if (recv >= 8) begin
               failures++; $display("FAIL stream_extra: got result %h expected none", p_d);
            end else if (p_d !== ve[recv] || ovf_d !== 1'b0) begin
               failures++; $display("FAIL stream_%0d: got %h/%b expected %h/0", recv, p_d, ovf_d, ve[recv]);
            end
            recv++;
         end
         if (in_valid && rdy_d) sent++;
         tick();
      end
      checks++; if (recv != 8) begin failures++; $display("FAIL stream_count: got %0d expected 8", recv); end
      checks++; if (stalls != 3) begin failures++; $display("FAIL stall_count: got %0d expected 3", stalls); end
   endtask

   task automatic test_reset_flight;
      out_ready = 1'b1;
      a = 10'd2; b = 10'd3; in_valid = 1'b1;
      tick();
      a = 10'd4; b = 10'd5;
      tick();
      in_valid = 1'b0;
      checks++; if (vld_d !== 1'b1) begin failures++; $display("FAIL flight_valid: got %b expected 1", vld_d); end
      #2;
      ap_rst_n = 1'b0;
      #1;
      checks++; if (vld_d !== 1'b0 || p_d !== 16'h0000 || ovf_d !== 1'b0) begin
         failures++; $display("FAIL midreset_clear: got %b/%h/%b expected 0/0000/0", vld_d, p_d, ovf_d);
      end
      tick();
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (vld_d !== 1'b0) begin failures++; $display("FAIL midreset_ghost_%0d: got %b expected 0", i, vld_d); end
      end
      send(10'd7, 10'd9);
      checks++; if (vld_d !== 1'b1 || p_d !== 16'd63) begin failures++; $display("FAIL post_reset: got %b/%0d expected 1/63", vld_d, p_d); end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_saturate();
      test_wrap_shift();
      test_unsigned();
      test_back_to_back();
      test_reset_flight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
